// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port RAM between instruction fetch and the
// load/store port. Data has fixed priority. A saturating starvation counter
// forces a fetch grant once data has won STARVE_LIMIT times in a row while
// fetch was waiting. Every access is an issue cycle followed by a response cycle.
module mem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [31:0]       inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_ack,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [31:0]       data_addr,
    input  logic [3:0]        data_sel,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_ack,
    output logic              stall_req,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_sel,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        W_DATA = 2'd1,
        W_INST = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // Byte-offset and high address bits never reach the word-addressed RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0],
                                data_addr[31:ADDR_W+2], data_addr[1:0]};

    // State and starvation counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Grant decision, RAM drive, response decode and stall request.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        ram_ce       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_sel      = 4'h0;
        ram_wdata    = 32'h0;
        inst_ack     = 1'b0;
        inst_rdata   = 32'h0;
        data_ack     = 1'b0;
        data_rdata   = 32'h0;
        stall_req    = 1'b0;

        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    // Data wins unless fetch has been passed over LIMIT times.
                    if (data_req && (!inst_req || starve_cnt_q < LIMIT)) begin
                        ram_ce    = 1'b1;
                        ram_we    = data_we;
                        ram_addr  = data_addr[ADDR_W+1:2];
                        ram_sel   = data_sel;
                        ram_wdata = data_wdata;
                        state_d   = W_DATA;
                        if (!inst_req)
                            starve_cnt_d = '0;
                        else if (starve_cnt_q != LIMIT)
                            starve_cnt_d = starve_cnt_q + 1'b1;
                    end else if (inst_req) begin
                        ram_ce       = 1'b1;
                        ram_sel      = 4'hF;
                        ram_addr     = inst_addr[ADDR_W+1:2];
                        state_d      = W_INST;
                        starve_cnt_d = '0;
                    end else begin
                        starve_cnt_d = '0;
                    end
                end
                W_DATA: begin
                    data_ack   = 1'b1;
                    data_rdata = ram_rdata;
                    state_d    = IDLE;
                end
                W_INST: begin
                    inst_ack   = 1'b1;
                    inst_rdata = ram_rdata;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase

            stall_req = (inst_req & ~inst_ack) | (data_req & ~data_ack);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural registered-read RAM.
module tb_mem_arbiter;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              inst_req;
    logic [31:0]       inst_addr;
    logic [31:0]       inst_rdata;
    logic              inst_ack;
    logic              data_req;
    logic              data_we;
    logic [31:0]       data_addr;
    logic [3:0]        data_sel;
    logic [31:0]       data_wdata;
    logic [31:0]       data_rdata;
    logic              data_ack;
    logic              stall_req;
    logic              ram_ce;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_sel;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_ack   (inst_ack),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_sel   (data_sel),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_ack   (data_ack),
        .stall_req  (stall_req),
        .ram_ce     (ram_ce),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_sel    (ram_sel),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: word i preloads to 0x1000_0000+i, word 3 holds a fetch
    // opcode, word 8 holds the store target. Read data is registered.
    logic [31:0] mem [0:1023];
    logic        init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + i;
            mem[3]    <= 32'h3401_1100;
            mem[8]    <= 32'h1122_3344;
            init_done <= 1'b1;
        end else if (ram_ce) begin
            ram_rdata <= mem[ram_addr];
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_sel[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held 10 cycles with both requests pending.
        rst = 1'b1; inst_req = 1'b1; inst_addr = 32'h0C;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h40;
        data_sel = 4'hF; data_wdata = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_outs", {28'h0, ram_ce, inst_ack, data_ack, stall_req}, 32'h0);
        end
        chk("rst_addr", 32'(ram_addr), 32'h0);

        // First grant after reset goes to data (word 16).
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", {30'h0, ram_ce, ram_we}, 32'h2);
        chk("post_rst_addr", 32'(ram_addr), 32'd16);
        cyc();
        @(negedge clk);
        chk("post_rst_ack", {30'h0, inst_ack, data_ack}, 32'h1);
        chk("post_rst_rdata", data_rdata, 32'h1000_0010);
        chk("post_rst_stall", 32'(stall_req), 32'h1);
        cyc(); inst_req = 1'b0; data_req = 1'b0;
        @(negedge clk);
        chk("idle_ce", {31'h0, ram_ce}, 32'h0);

        // Lone fetch of word 3.
        cyc(); inst_req = 1'b1; inst_addr = 32'h0C;
        @(negedge clk);
        chk("fetch_issue", {26'h0, ram_ce, ram_we, ram_sel}, 32'h2F);
        chk("fetch_addr", 32'(ram_addr), 32'd3);
        chk("fetch_stall_n", 32'(stall_req), 32'h1);
        cyc();
        @(negedge clk);
        chk("fetch_ack", {30'h0, inst_ack, ram_ce}, 32'h2);
        chk("fetch_rdata", inst_rdata, 32'h3401_1100);
        chk("fetch_stall_n1", 32'(stall_req), 32'h0);
        cyc(); inst_req = 1'b0;
        @(negedge clk);
        chk("fetch_rdata_idle", inst_rdata, 32'h0);

        // Partial store to 0x20 over 0x11223344, then load it back.
        cyc(); data_req = 1'b1; data_we = 1'b1; data_addr = 32'h20;
        data_sel = 4'b0011; data_wdata = 32'hAABB_CCDD;
        @(negedge clk);
        chk("store_issue", {26'h0, ram_ce, ram_we, ram_sel}, 32'h33);
        chk("store_addr", 32'(ram_addr), 32'd8);
        chk("store_wdata", ram_wdata, 32'hAABB_CCDD);
        cyc(); data_wdata = 32'hDEAD_BEEF;  // late change must not matter
        @(negedge clk);
        chk("store_ack", {30'h0, data_ack, ram_ce}, 32'h2);
        cyc(); data_we = 1'b0; data_sel = 4'hF;
        @(negedge clk);
        chk("load_issue", {30'h0, ram_ce, ram_we}, 32'h2);
        cyc();
        @(negedge clk);
        chk("load_ack", 32'(data_ack), 32'h1);
        chk("load_rdata", data_rdata, 32'h1122_CCDD);
        cyc(); data_req = 1'b0;
        @(negedge clk);
        chk("load_rdata_idle", data_rdata, 32'h0);
        chk("idle_stall", 32'(stall_req), 32'h0);

        // Contention: D,D,D,D,I repeating; first inst_ack in the 10th cycle.
        cyc(); inst_req = 1'b1; inst_addr = 32'h0C;
        data_req = 1'b1; data_addr = 32'h40;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) cyc();
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("cont_issue_ce", 32'(ram_ce), 32'h1);
                chk("cont_issue_addr", 32'(ram_addr), ((k / 2) % 5 == 4) ? 32'd3 : 32'd16);
            end else begin
                chk("cont_acks", {30'h0, inst_ack, data_ack},
                    ((k / 2) % 5 == 4) ? 32'h2 : 32'h1);
            end
        end
        cyc(); inst_req = 1'b0; data_req = 1'b0;
        @(negedge clk);
        chk("cont_idle", {31'h0, ram_ce}, 32'h0);

        // Data-only traffic for 8 accesses.
        cyc(); data_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) cyc();
            @(negedge clk);
            if (k % 2 == 1) chk("donly_ack", {30'h0, inst_ack, data_ack}, 32'h1);
        end
        // Fetch joins in the next issue cycle: 4 data grants precede it.
        cyc(); inst_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) cyc();
            @(negedge clk);
            if (k % 2 == 0)
                chk("clr_grant_addr", 32'(ram_addr), (k == 8) ? 32'd3 : 32'd16);
        end
        cyc(); inst_req = 1'b0; data_req = 1'b0;
        @(negedge clk);

        // Reset during the response cycle of a load.
        cyc(); data_req = 1'b1; data_we = 1'b0; data_addr = 32'h20;
        @(negedge clk);
        chk("mid_issue", {31'h0, ram_ce}, 32'h1);
        cyc(); rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ack", {31'h0, data_ack}, 32'h0);
        chk("mid_rst_rdata", data_rdata, 32'h0);
        chk("mid_rst_stall", 32'(stall_req), 32'h0);
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk("mid_regrant", {31'h0, ram_ce}, 32'h1);
        chk("mid_regrant_addr", 32'(ram_addr), 32'd8);
        cyc();
        @(negedge clk);
        chk("mid_ack", {31'h0, data_ack}, 32'h1);
        chk("mid_rdata", data_rdata, 32'h1122_CCDD);
        cyc(); data_req = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port instruction/data RAM between the instruction-fetch port and the load/store (MEM stage) port of the openmips core.
- Fixed priority goes to the data port. A starvation guard keeps fetch from being locked out.
- Sits in top between openmips and ram. Raises a stall request to the pipeline ctrl while any request is unserved.
- One transaction costs 2 cycles: an issue cycle followed by a response cycle.

Parameters:
ADDR_W, 10, RAM word-address width; RAM word index = byte_addr[ADDR_W+1:2]
STARVE_LIMIT, 4, consecutive data grants allowed while inst_req is waiting before fetch is forced; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
inst_req  input  1  fetch request; held until inst_ack
inst_addr  input  32  fetch byte address; bits [1:0] ignored
inst_rdata  output  32  fetch data; valid only while inst_ack=1
inst_ack  output  1  one-cycle response pulse for fetch
data_req  input  1  load/store request; held until data_ack
data_we  input  1  1=store, 0=load
data_addr  input  32  byte address; bits [1:0] ignored
data_sel  input  4  byte enables for store
data_wdata  input  32  store data
data_rdata  output  32  load data; valid only while data_ack=1
data_ack  output  1  one-cycle response pulse for load/store
stall_req  output  1  to pipeline ctrl; 1 while any req is high and its ack is not asserted this cycle
ram_ce  output  1  RAM chip enable
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM word address
ram_sel  output  4  RAM byte enables
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM read data; registered, valid the cycle after ce=1

Behaviour:
- Reset is synchronous: with rst=1 at a rising edge, the next state is IDLE and starve_cnt=0.
  - All outputs are combinational from state and inputs. While rst=1 they are forced to 0: ram_ce, ram_we, acks, stall_req.
  - ram_addr, ram_sel, ram_wdata, inst_rdata and data_rdata are also driven to 0 while rst=1.
- State IDLE (issue cycle):
  - data_req=1 and (inst_req=0 or starve_cnt<STARVE_LIMIT): grant DATA.
    - ram_ce=1, ram_we=data_we, ram_addr=data_addr[ADDR_W+1:2], ram_sel=data_sel, ram_wdata=data_wdata.
    - Next state W_DATA.
  - Otherwise, if inst_req=1: grant INST.
    - ram_ce=1, ram_we=0, ram_sel=4'hF, ram_addr=inst_addr[ADDR_W+1:2].
    - Next state W_INST.
  - Neither request: ram_ce=0, stay in IDLE.
- State W_DATA (response cycle): data_ack=1, data_rdata=ram_rdata (stores also ack here; data_rdata is don't-care for a store). ram_ce=0. Next state IDLE.
- State W_INST (response cycle): inst_ack=1, inst_rdata=ram_rdata. ram_ce=0. Next state IDLE.
- When not acked, inst_rdata and data_rdata are 0.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments on each DATA grant issued while inst_req=1, saturating at STARVE_LIMIT.
  - Clears to 0 on an INST grant, or on any IDLE cycle with inst_req=0.
- Latency: request seen in IDLE with a grant → ack on the next cycle. Minimum 2 cycles per access, and at most one ack per cycle. The response state always returns to IDLE, even if the requester's req has already been lowered.
- stall_req = (inst_req & ~inst_ack) | (data_req & ~data_ack), gated to 0 during rst.
- Simultaneous requests: data wins unless starve_cnt==STARVE_LIMIT, in which case inst wins.
- Requests must stay stable from assertion until ack. Changes to addr/we/sel/wdata during the response cycle do not affect the completed access.
- Reset mid-transaction: rst=1 during W_DATA or W_INST suppresses the ack. A store already issued to RAM remains written. The requester re-issues after reset.

Test Plan:
- Reset: rst=1 for 10 cycles with both reqs high → ram_ce=0, inst_ack=data_ack=0, stall_req=0 throughout. After rst falls, the first grant goes to data.
- Lone fetch: RAM word 3=0x34011100, inst_req with inst_addr=0x0C → ram_ce=1, ram_addr=3 in cycle N; inst_ack=1 and inst_rdata=0x34011100 in N+1. stall_req=1 in N and 0 in N+1.
- Store then load: data store to addr 0x20, sel=4'b0011, wdata=0xAABBCCDD over prior word 0x11223344 → ack after 2 cycles. A following load of 0x20 returns data_rdata=0x1122CCDD.
- Contention: both reqs held continuously with STARVE_LIMIT=4 → grant order D,D,D,D,I repeating. inst_ack first fires 10 cycles after the start, and there is never more than one ack per cycle.
- Starve counter clear: data-only traffic for 8 accesses, then inst_req rises together with data_req → data gets 4 grants before inst. The counter does not start pre-saturated.
- Reset mid-access: assert rst during W_DATA of a load → data_ack stays 0. After release, the held data_req is re-granted and acked with correct data.
